// File: rtl/chan_demux_buffer.sv
// Receiving end of the channel fabric: steers one (select, data) word per cycle
// into per-channel holding registers, each held valid until its consumer acks.
module chan_demux_buffer #(
  parameter int unsigned CHANNELS = 32,
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [SEL_W-1:0]                 in_sel,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic [CHANNELS-1:0][WIDTH-1:0]   out_data,
  output logic [CHANNELS-1:0]              out_valid,
  input  logic [CHANNELS-1:0]              out_ack,
  output logic [SEL_W:0]                   occupancy,
  output logic [SEL_W-1:0]                 last_sel,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int unsigned OCC_W = SEL_W + 1;

  logic                acc;
  logic                stall;
  logic [CHANNELS-1:0] sel_hot;
  logic [CHANNELS-1:0] valid_next;
  logic [OCC_W-1:0]    ack_cnt;
  logic [OCC_W-1:0]    occ_next;

  // A full slot frees itself in the same cycle it is acked, so no bubble is needed.
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ack[in_sel];
    acc      = in_valid & in_ready;
    stall    = in_valid & ~in_ready;
  end

  always_comb begin
    sel_hot         = '0;
    sel_hot[in_sel] = 1'b1;
  end

  // Acks clear their flag; a same-cycle write to that channel wins.
  always_comb begin
    valid_next = (out_valid & ~out_ack) | (acc ? sel_hot : '0);
  end

  // Any accepted write adds one; a write to an acked slot cancels that slot's ack.
  always_comb begin
    ack_cnt = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      ack_cnt = ack_cnt + OCC_W'(out_ack[i] & out_valid[i]);
    end
    occ_next = occupancy + OCC_W'(acc) - ack_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= '0;
      occupancy <= '0;
      last_sel  <= '0;
      stall_cnt <= '0;
    end else begin
      out_valid <= valid_next;
      occupancy <= occ_next;
      if (acc) begin
        out_data[in_sel] <= in_data;
        last_sel         <= in_sel;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chan_demux_buffer.sv
// Self-checking bench for chan_demux_buffer: directed table, corner sequences and
// randomized traffic compared against a slot-level reference model.
module tb_chan_demux_buffer;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [4:0]            in_sel;
  logic [19:0]           in_data;
  logic                  in_ready;
  logic [31:0][19:0]     out_data;
  logic [31:0]           out_valid;
  logic [31:0]           out_ack;
  logic [5:0]            occupancy;
  logic [4:0]            last_sel;
  logic [15:0]           stall_cnt;

  chan_demux_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occupancy (occupancy),
    .last_sel  (last_sel),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: slot contents and flags as plain arrays.
  logic [31:0]       m_valid;
  logic [31:0][19:0] m_data;
  logic [4:0]        m_last;
  int                m_stall;
  logic              rdy_seen;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popcnt(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_clear();
    m_valid = '0;
    m_data  = '0;
    m_last  = '0;
    m_stall = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 640'(out_valid), 640'(m_valid));
    chk({tag, "_data"},  640'(out_data),  640'(m_data));
    chk({tag, "_occ"},   640'(occupancy), 640'(popcnt(m_valid)));
    chk({tag, "_last"},  640'(last_sel),  640'(m_last));
    chk({tag, "_stall"}, 640'(stall_cnt), 640'(m_stall));
  endtask

  // One clock cycle: drive after negedge, check ready, advance model at posedge.
  task automatic step(input logic v, input logic [4:0] s, input logic [19:0] d,
                      input logic [31:0] k);
    logic exp_rdy;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    out_ack  = k;
    #1;
    exp_rdy  = !m_valid[s] || k[s];
    rdy_seen = in_ready;
    chk("in_ready", 640'(in_ready), 640'(exp_rdy));
    @(posedge clk);
    m_valid = m_valid & ~k;
    if (v && exp_rdy) begin
      m_valid[s] = 1'b1;
      m_data[s]  = d;
      m_last     = s;
    end else if (v && m_stall < 65535) begin
      m_stall++;
    end
    #1;
    check_model("step");
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Occupancy must track the flag count on every cycle.
  always @(negedge clk) begin
    if (!rst) chk("occ_invariant", 640'(occupancy), 640'(popcnt(out_valid)));
  end

  typedef struct {
    logic        v;
    logic [4:0]  s;
    logic [19:0] d;
    logic [31:0] k;
    logic        rdy;
    logic [5:0]  occ;
    logic [4:0]  last;
  } vec_t;

  vec_t tbl[34];

  initial begin
    int occ0;
    int cycles;
    logic [31:0] k;

    // Fill ch 0..31, then a same-cycle ack+write on ch 7, then a stalled offer on ch 5.
    for (int i = 0; i < 32; i++) begin
      tbl[i] = '{v: 1'b1, s: 5'(i), d: 20'(i), k: '0, rdy: 1'b1, occ: 6'(i + 1), last: 5'(i)};
    end
    tbl[32] = '{v: 1'b1, s: 5'd7, d: 20'h22222, k: 32'h0000_0080, rdy: 1'b1, occ: 6'd32, last: 5'd7};
    tbl[33] = '{v: 1'b1, s: 5'd5, d: 20'h12345, k: '0,            rdy: 1'b0, occ: 6'd32, last: 5'd7};

    rst = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ack = '0;
    model_clear();
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 640'(out_valid), 640'(0));
    chk("rst_data",  640'(out_data),  640'(0));
    chk("rst_occ",   640'(occupancy), 640'(0));
    chk("rst_last",  640'(last_sel),  640'(0));
    chk("rst_stall", 640'(stall_cnt), 640'(0));
    chk("rst_ready", 640'(in_ready),  640'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].k);
      chk("tbl_ready", 640'(rdy_seen),  640'(tbl[i].rdy));
      chk("tbl_occ",   640'(occupancy), 640'(tbl[i].occ));
      chk("tbl_last",  640'(last_sel),  640'(tbl[i].last));
      if (i == 31) chk("fill_valid", 640'(out_valid), 640'(32'hFFFF_FFFF));
    end
    chk("tbl_data7", 640'(out_data[7]), 640'(20'h22222));

    // Backpressure on a held slot from a fresh reset.
    do_reset();
    step(1'b1, 5'd5, 20'hABCDE, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd5, 20'h12345, '0);
      chk("bp_ready", 640'(rdy_seen), 640'(0));
    end
    chk("bp_stall", 640'(stall_cnt),   640'(3));
    chk("bp_data5", 640'(out_data[5]), 640'(20'hABCDE));

    // Same-cycle ack and write on ch 7.
    step(1'b1, 5'd7, 20'h11111, '0);
    occ0 = int'(occupancy);
    step(1'b1, 5'd7, 20'h22222, 32'h0000_0080);
    chk("sc_valid7", 640'(out_valid[7]), 640'(1));
    chk("sc_data7",  640'(out_data[7]),  640'(20'h22222));
    chk("sc_occ",    640'(occupancy),    640'(occ0));

    // Two acks plus a write to an empty slot.
    step(1'b1, 5'd3, 20'h00333, '0);
    step(1'b1, 5'd9, 20'h00999, '0);
    occ0 = int'(occupancy);
    step(1'b1, 5'd12, 20'h0CCCC, (32'd1 << 3) | (32'd1 << 9));
    chk("mix_occ",  640'(occupancy),    640'(occ0 - 1));
    chk("mix_v3",   640'(out_valid[3]), 640'(0));
    chk("mix_v9",   640'(out_valid[9]), 640'(0));
    chk("mix_v12",  640'(out_valid[12]), 640'(1));

    // Spurious ack on an empty channel changes nothing.
    occ0 = int'(occupancy);
    step(1'b0, 5'd20, 20'h0, 32'd1 << 20);
    chk("spur_occ", 640'(occupancy), 640'(occ0));

    // Randomized traffic with collision-heavy selects and sparse acks.
    for (int i = 0; i < 600; i++) begin
      k = $urandom & $urandom & $urandom;
      step($urandom_range(0, 3) != 0,
           (i % 2 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
           20'($urandom), k);
    end

    // Saturate the stall counter against a held slot.
    if (!m_valid[0]) step(1'b1, 5'd0, 20'h0F0F0, '0);
    in_valid = 1'b1; in_sel = 5'd0; in_data = 20'h55555; out_ack = '0;
    cycles = 65540;
    repeat (cycles) @(negedge clk);
    m_stall = (m_stall + cycles > 65535) ? 65535 : m_stall + cycles;
    chk("sat_stall", 640'(stall_cnt), 640'(16'hFFFF));
    check_model("sat");
    step(1'b1, 5'd0, 20'h55555, '0);
    chk("sat_nowrap", 640'(stall_cnt), 640'(16'hFFFF));

    // Asynchronous reset between edges with ten slots full.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i), 20'(i + 100), '0);
    chk("pre_rst_occ", 640'(occupancy), 640'(10));
    in_valid = 1'b0; out_ack = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 640'(out_valid), 640'(0));
    chk("arst_data",  640'(out_data),  640'(0));
    chk("arst_occ",   640'(occupancy), 640'(0));
    chk("arst_last",  640'(last_sel),  640'(0));
    chk("arst_stall", 640'(stall_cnt), 640'(0));
    chk("arst_ready", 640'(in_ready),  640'(1));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 5'd2, 20'h00222, '0);
    chk("post_rst_occ", 640'(occupancy), 640'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_demux_buffer.md
# chan_demux_buffer

Buffered, handshaked 32-channel distributor: the receiving end of the 32×20-bit channel fabric. It accepts one (select, data) word per cycle from the shared 20-bit bus and latches it into one of 32 per-channel holding registers. Each channel then presents its data with a valid flag until that channel's consumer acknowledges it. It is the sequential counterpart to the channel-select MUX: a word steered onto the bus by index here lands back in that index's slot, with backpressure when the slot is still occupied.

## Interface
Parameters:
- CHANNELS, 32, number of channels; fixed at 32 in this revision.
- SEL_W, 5, select width, equal to log2(CHANNELS).
- WIDTH, 20, data width per channel.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  producer offers a word this cycle.
- in_sel  input  SEL_W  destination channel, unsigned.
- in_data  input  WIDTH  payload.
- in_ready  output  1  combinational; the word is accepted this cycle when in_valid and in_ready are both high.
- out_data  output  [CHANNELS-1:0][WIDTH-1:0]  per-channel holding registers.
- out_valid  output  CHANNELS  per-channel data-present flags.
- out_ack  input  CHANNELS  per-channel consume strobes.
- occupancy  output  SEL_W+1  registered count of set out_valid bits, range 0..32.
- last_sel  output  SEL_W  channel of the most recent accepted write.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

## Operation
- Define acc = in_valid & in_ready.
- in_ready = ~out_valid[in_sel] | out_ack[in_sel]. A full slot accepts a new word only in the same cycle its old word is consumed.
- Write: when acc, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1 at the next edge. last_sel <= in_sel.
- Ack: for each i with out_ack[i] & out_valid[i], out_valid[i] <= 0, unless channel i is written this same cycle.
- Ack when out_valid[i] = 0 has no effect.
- out_data[i] holds its value after an ack; it is not cleared. Consumers must qualify it with out_valid[i].
- Ack and write on the same channel in the same cycle: out_valid stays 1, out_data takes the new word, occupancy is unchanged.
- Occupancy update each cycle: occupancy_next = occupancy + w − a.
  - w = 1 if the write goes to a channel that was empty, or to a channel that is simultaneously acked.
  - a = number of effective acks (acks on channels with out_valid set).
  - A write to a simultaneously acked channel therefore contributes net 0.
  - The invariant occupancy == popcount(out_valid) must hold every cycle.
- stall_cnt increments by 1 on each cycle with in_valid & ~in_ready. It saturates at 2^CNT_W−1 and never wraps.
- in_sel is always in range because CHANNELS = 2^SEL_W; no error path exists.
- Reset values (rst high, asynchronous): out_valid = 0, out_data = 0 on all channels, occupancy = 0, last_sel = 0, stall_cnt = 0.
- in_ready during reset is 1: it is derived from the cleared out_valid and does not depend on any extra gating.

## Timing
- Write latency: a word accepted at edge N is visible on out_data/out_valid after edge N, i.e. in cycle N+1.
- in_ready has a combinational path from in_sel, out_valid and out_ack. There is no path from in_data.
- Throughput: one word per cycle to any mix of empty channels. Back-to-back writes to the same channel need a same-cycle ack on the second beat.
- Ack takes effect at the next edge. A freed slot can be written in the ack cycle itself; no bubble is required.
- Reset mid-operation: all pending words are discarded immediately. The producer must re-send anything it had not seen consumed.
- Assertion of rst is asynchronous. Release is synchronized externally; the block does not add a synchronizer.

## Test plan
- Reset then fill: write ch 0..31 with data 0x00000+i on consecutive cycles → in_ready high throughout; after the last edge out_valid = 0xFFFFFFFF, occupancy = 32, last_sel = 31.
- Backpressure: ch 5 holds 0xABCDE with no ack; offer 0x12345 to ch 5 for 3 cycles → in_ready = 0 for those 3 cycles; stall_cnt = 3; out_data[5] remains 0xABCDE.
- Same-cycle ack and write: ch 7 valid with 0x11111; assert out_ack[7] while writing 0x22222 to ch 7 → out_valid[7] stays 1, out_data[7] = 0x22222, occupancy unchanged.
- Mixed update: ch 3 and ch 9 valid; ack both while writing empty ch 12 → occupancy decreases by 1; out_valid[3] = out_valid[9] = 0, out_valid[12] = 1.
- Spurious ack and saturation: ack ch 20 while it is empty → no change anywhere; force 65540 stall cycles → stall_cnt = 0xFFFF.
- Async reset mid-stream: assert rst between edges while occupancy = 10 → all outputs zero immediately, without waiting for a clock edge; the first write after release goes to ch 2 → occupancy = 1.
- All scenarios: checker asserts occupancy == popcount(out_valid) every cycle.
